// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and defaults for the clock divider controller
package clk_div_pkg;

  localparam int DIV_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [DIV_CNT_W-1:0] period;
    logic [DIV_CNT_W-1:0] high;
  } div_cfg_t;

  localparam logic [DIV_CNT_W-1:0] DIV_DEF_PERIOD = 8'd10;
  localparam logic [DIV_CNT_W-1:0] DIV_DEF_HIGH   = 8'd5;

  // A usable config needs a period of at least two cycles and a low phase.
  function automatic logic cfg_is_valid(input div_cfg_t c);
    return (c.period != '0) && (c.high < c.period);
  endfunction

endpackage

// File: rtl/div_phase_counter.sv
// rtl/div_phase_counter.sv - phase counter producing clk_out, tick and wrap
module div_phase_counter
  import clk_div_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 load0,
  input  div_cfg_t             cfg,
  output logic                 wrap,
  output logic                 clk_out,
  output logic                 tick,
  output logic [DIV_CNT_W-1:0] count
);

  logic [DIV_CNT_W-1:0] count_q, count_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;
  logic [DIV_CNT_W:0]   next_cnt;

  // One extra bit so a period of 2^W-1 compares without overflow.
  assign next_cnt = {1'b0, count_q} + {{DIV_CNT_W{1'b0}}, 1'b1};
  assign wrap     = (count_q == cfg.period);

  always_comb begin
    count_d = '0;
    clk_d   = 1'b0;
    tick_d  = 1'b0;
    if (load0) begin
      clk_d  = 1'b1;
      tick_d = 1'b1;
    end else if (en && !wrap) begin
      count_d = next_cnt[DIV_CNT_W-1:0];
      clk_d   = (next_cnt <= {1'b0, cfg.high});
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign count   = count_q;
  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - run/stop FSM, config handshake and shadow for the clock divider
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W      = DIV_CNT_W,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  div_state_e state_q, state_d;
  div_cfg_t   active_q, active_d;
  div_cfg_t   shadow_q, shadow_d;
  logic       cfg_err_q, cfg_err_d;
  div_cfg_t   req;
  logic       xfer, req_ok, wrap, load0;

  assign req       = '{period: cfg_period, high: cfg_high};
  assign cfg_ready = (state_q != ST_PEND);
  assign busy      = (state_q != ST_IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign req_ok    = cfg_is_valid(req);
  assign load0     = run && ((state_q == ST_IDLE) || (busy && wrap));

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    cfg_err_d = xfer && !req_ok;
    case (state_q)
      ST_IDLE: begin
        if (xfer && req_ok) active_d = req;
        if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Stopping at a wrap leaves nothing to shadow: apply directly.
        if (wrap && !run) begin
          state_d = ST_IDLE;
          if (xfer && req_ok) active_d = req;
        end else if (xfer && req_ok) begin
          shadow_d = req;
          state_d  = ST_PEND;
        end
      end
      ST_PEND: begin
        if (wrap) begin
          active_d = shadow_q;
          state_d  = run ? ST_RUN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      active_q  <= '{period: DIV_CNT_W'(DEF_PERIOD), high: DIV_CNT_W'(DEF_HIGH)};
      shadow_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  div_phase_counter u_phase (
    .clk_in  (clk_in),
    .reset   (reset),
    .en      (busy),
    .load0   (load0),
    .cfg     (active_q),
    .wrap    (wrap),
    .clk_out (clk_out),
    .tick    (tick),
    .count   (count)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - scoreboard bench for clk_div_ctrl period/phase behaviour
module tb_clk_div_ctrl;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       run;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_period;
  logic [7:0] cfg_high;
  logic       cfg_err;
  logic       clk_out;
  logic       tick;
  logic [7:0] count;
  logic       busy;

  typedef struct {
    int len;
    int hi;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   in_period = 0;
  int   mon_len = 0;
  int   mon_hi  = 0;

  always #5 clk_in = ~clk_in;

  clk_div_ctrl dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .run        (run),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .tick       (tick),
    .count      (count),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int len, input int hi, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back('{len: len, hi: hi});
  endtask

  // A period ends when the next one starts or the divider drops to idle.
  always @(negedge clk_in) begin
    if (reset) begin
      in_period = 0;
    end else begin
      if (in_period && (tick || !busy)) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_period", 0, 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("period_len", mon_len, e.len);
          chk("period_high", mon_hi, e.hi);
        end
      end
      if (tick) begin
        in_period = 1;
        mon_len   = 0;
        mon_hi    = 0;
      end else if (!busy) begin
        in_period = 0;
      end
      if (in_period) begin
        mon_len++;
        if (clk_out) mon_hi++;
      end
    end
  end

  task automatic wait_q(input int n, input string tag);
    int b = 0;
    while (sb_q.size() > n && b < 400) begin
      @(negedge clk_in);
      b++;
    end
    chk(tag, (sb_q.size() <= n), 1);
  endtask

  task automatic wait_count(input logic [7:0] v, input string tag);
    int b = 0;
    while (count != v && b < 100) begin
      @(negedge clk_in);
      b++;
    end
    chk(tag, count, v);
  endtask

  task automatic wait_tick(input string tag);
    int b = 0;
    do begin
      @(negedge clk_in);
      b++;
    end while (!tick && b < 100);
    chk(tag, tick, 1);
  endtask

  task automatic drive_cfg(input logic v, input logic [7:0] p, input logic [7:0] h);
    cfg_valid  = v;
    cfg_period = p;
    cfg_high   = h;
  endtask

  initial begin
    int max_cnt;
    int b;
    reset = 1'b1;
    run   = 1'b0;
    drive_cfg(1'b0, 8'd0, 8'd0);
    repeat (3) @(negedge clk_in);
    chk("rst_count", count, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);

    // Defaults: 11-cycle period, 6 high
    run = 1'b1;
    push(11, 6, 4);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_in);
      chk("def_count_seq", count, i);
      if (i == 0) chk("def_first_tick", tick, 1);
      if (i == 1) chk("def_tick_drop", tick, 0);
      if (i == 5) chk("def_last_high", clk_out, 1);
      if (i == 6) chk("def_first_low", clk_out, 0);
    end
    wait_q(1, "def_drain");

    // Invalid configs are discarded with a one-cycle error pulse
    push(11, 6, 2);
    drive_cfg(1'b1, 8'd3, 8'd3);
    @(negedge clk_in);
    chk("inv1_err", cfg_err, 1);
    chk("inv1_ready", cfg_ready, 1);
    drive_cfg(1'b1, 8'd0, 8'd0);
    @(negedge clk_in);
    chk("inv2_err", cfg_err, 1);
    chk("inv2_ready", cfg_ready, 1);
    drive_cfg(1'b0, 8'd0, 8'd0);
    @(negedge clk_in);
    chk("inv_err_clear", cfg_err, 0);
    wait_q(1, "inv_drain");

    // Valid {3,1} mid-period: current period completes, then 4-cycle periods
    wait_count(8'd4, "cfg31_at4");
    push(4, 2, 3);
    drive_cfg(1'b1, 8'd3, 8'd1);
    @(negedge clk_in);
    drive_cfg(1'b0, 8'd0, 8'd0);
    chk("cfg31_ready_low", cfg_ready, 0);
    chk("cfg31_no_err", cfg_err, 0);
    chk("cfg31_busy", busy, 1);
    wait_tick("cfg31_wrap");
    chk("cfg31_ready_back", cfg_ready, 1);
    wait_q(1, "cfg31_drain");

    // Second request held while pending is taken only after the wrap
    push(6, 3, 1);
    push(3, 1, 2);
    drive_cfg(1'b1, 8'd5, 8'd2);
    @(negedge clk_in);
    drive_cfg(1'b1, 8'd2, 8'd0);
    chk("hold_ready_low", cfg_ready, 0);
    wait_tick("hold_wrap");
    chk("hold_ready_after_wrap", cfg_ready, 1);
    @(negedge clk_in);
    chk("hold_taken", cfg_ready, 0);
    drive_cfg(1'b0, 8'd0, 8'd0);
    wait_q(1, "hold_drain");

    // Back to defaults, then stop at count 2
    push(11, 6, 1);
    drive_cfg(1'b1, 8'd10, 8'd5);
    @(negedge clk_in);
    drive_cfg(1'b0, 8'd0, 8'd0);
    wait_q(1, "restore_drain");
    wait_count(8'd2, "stop_at2");
    run = 1'b0;
    max_cnt = 0;
    b = 0;
    while (busy && b < 50) begin
      if (count > max_cnt) max_cnt = count;
      @(negedge clk_in);
      b++;
    end
    chk("stop_busy", busy, 0);
    chk("stop_max_count", max_cnt, 10);
    chk("stop_clk_out", clk_out, 0);
    chk("stop_count", count, 0);
    @(negedge clk_in);
    chk("stop_sb_empty", sb_q.size(), 0);
    chk("stop_tick", tick, 0);
    push(11, 6, 1);
    run = 1'b1;
    @(negedge clk_in);
    chk("restart_tick", tick, 1);
    chk("restart_clk_out", clk_out, 1);

    // Reset mid-high with a pending shadow loses the shadow
    wait_count(8'd2, "rst_at2");
    drive_cfg(1'b1, 8'd3, 8'd1);
    @(negedge clk_in);
    drive_cfg(1'b0, 8'd0, 8'd0);
    chk("rst_pend", cfg_ready, 0);
    chk("rst_pre_clk", clk_out, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_clk_out", clk_out, 0);
    chk("arst_count", count, 0);
    chk("arst_tick", tick, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cfg_ready, 1);
    sb_q.delete();
    repeat (2) @(negedge clk_in);
    push(11, 6, 2);
    reset = 1'b0;
    @(negedge clk_in);
    chk("post_rst_tick", tick, 1);
    wait_q(1, "post_rst_drain");
    repeat (3) @(negedge clk_in);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the team's programmable clock divider. Holds the active divide configuration (terminal count, high-phase length) and a one-deep shadow register loaded through a valid/ready port. It applies new configurations only at period boundaries, so `clk_out` never glitches. It also starts and stops the divider cleanly under a `run` level input, and sits between the CPU-side config registers and the divided-clock consumers.

## Interface
- `CNT_W`, 8, counter and config width
- `DEF_PERIOD`, 10, terminal count loaded at reset; period = `DEF_PERIOD`+1 cycles
- `DEF_HIGH`, 5, last count value with `clk_out` high, loaded at reset
- `clk_in`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `run`  in  1  level; 1 = divider running
- `cfg_valid`  in  1  config request valid
- `cfg_ready`  out  1  controller can accept a config
- `cfg_period`  in  CNT_W  requested terminal count
- `cfg_high`  in  CNT_W  requested last-high count
- `cfg_err`  out  1  one-cycle pulse: accepted config was invalid and discarded
- `clk_out`  out  1  divided clock (registered)
- `tick`  out  1  one-cycle pulse in the first cycle of every period (count==0)
- `count`  out  CNT_W  current phase counter
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, RUN, PEND (RUN with a shadow config waiting).
- Reset (async, immediate): state IDLE; `count`=0, `clk_out`=0, `tick`=0, `cfg_err`=0. Active config = `DEF_PERIOD`/`DEF_HIGH`. Shadow is cleared. Reset mid-operation discards the shadow.
- `cfg_ready` = 1 in IDLE and RUN, 0 in PEND. A transfer occurs when `cfg_valid` && `cfg_ready` at a rising edge.
- Validity: a config requires `cfg_period` ≥ 1 and `cfg_high` < `cfg_period`. An invalid config still completes the handshake. It pulses `cfg_err` in the next cycle and changes no state or config.
- Valid config in IDLE: written to the active config at the transfer edge; stay in IDLE.
- Valid config in RUN: written to the shadow; go to PEND. This includes a transfer on the wrap edge itself; that shadow waits for the following wrap.
- IDLE, `run`=1 sampled: go to RUN; `count`<=0, `clk_out`<=1, `tick`<=1.
- RUN/PEND, `count` != period: `count`<=`count`+1; `clk_out`<=(`count`+1 ≤ high); `tick`<=0.
- RUN/PEND, `count` == period (wrap):
  - PEND: load shadow into active, go to RUN.
  - If `run`=1: `count`<=0, `clk_out`<=1, `tick`<=1, using the newly active config.
  - If `run`=0: go to IDLE; `count`<=0, `clk_out`<=0, `tick`<=0.
- A `run` deassertion never truncates a period. The current period always completes.
- Arithmetic: unsigned, CNT_W bits. The compare `count`+1 ≤ high is done at CNT_W+1 bits, so period = 2^CNT_W−1 cannot overflow. The maximum period is 2^CNT_W cycles.

## Timing
- `clk_out` is high for high+1 cycles and low for period−high cycles.
- First `tick`/`clk_out` rise: 1 cycle after `run` is sampled high in IDLE.
- Config latency:
  - IDLE: effective for the next period started.
  - RUN: effective at the first wrap after the transfer edge, or the second if the transfer is on a wrap edge.
- `cfg_err`: exactly 1 cycle, the cycle after the transfer.
- `cfg_ready` returns to 1 in the cycle after the shadow loads.
- All outputs are registered except `cfg_ready` and `busy`, which decode state only.

## Structure
- Package `clk_div_pkg` holds:
  - state enum (IDLE/RUN/PEND)
  - a `div_cfg_t` struct {period, high}
  - default constants
- Sub-module `div_phase_counter`: the counter/`clk_out`/`tick` datapath, with inputs `en`, `load0`, and the active cfg, and a `wrap` output. `clk_div_ctrl` holds the FSM, handshake, shadow, and validity check.

## Test plan
- Defaults, `run`=1 held: `tick` every 11 cycles; `clk_out` 6 cycles high, 5 low; `count` sequence 0..10.
- Running, valid cfg {3,1} accepted at `count`=4: current period completes 11 cycles. Then `tick` every 4 cycles, with `clk_out` high 2 and low 2. `cfg_ready`=0 until the wrap.
- Cfg {3,3} and cfg {0,0}: each gives a `cfg_err` 1-cycle pulse; the period is still 11; `cfg_ready` stays 1.
- Second `cfg_valid` held while in PEND: not accepted until the cycle after the wrap, then taken into the shadow.
- `run` dropped at `count`=2: counting continues to 10, then IDLE with `clk_out`=0 and `busy`=0. Re-raising `run` gives `tick` 1 cycle later.
- `reset` asserted mid-high-phase with a pending shadow: outputs go to 0 immediately. After release with `run`=1, the period is 11 (the shadow is lost).
